// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_pkg
// Brief    : Shared FSM/grant types and wait-count width for the SRAM arbiter.
// Revision : 1.0
// ============================================================================
package sram_arb_pkg;

  localparam int c_wait_cnt_w = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_MEM  = 2'd2
  } gnt_t;

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : wait_counter
// Brief    : Loadable down-counter; done is high while the count is zero.
// Revision : 1.0
// ============================================================================
module wait_counter
  import sram_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [c_wait_cnt_w-1:0] load_val,
  input  logic                    en,
  output logic                    done
);

  logic [c_wait_cnt_w-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Shares one SRAM port between instruction fetch and MEM-stage
//            accesses. Define STARVE_GUARD_EN to force a fetch grant after
//            STARVE_LIMIT consecutive data grants made while fetch waits.
// Revision : 1.0
// ============================================================================
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        freeze,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic        sram_we,
  output logic        sram_oe,
  input  logic [31:0] sram_rdata
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || STARVE_LIMIT < 1) begin : g_param_check
    $error("sram_arbiter: WAIT_CYCLES must be 1..15 and STARVE_LIMIT >= 1");
  end

  localparam logic [c_wait_cnt_w-1:0] c_wait_load = c_wait_cnt_w'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  gnt_t        r_gnt;
  gnt_t        w_gnt;
  logic        w_mem_req;
  logic        w_force_if;
  logic        w_cnt_load;
  logic        w_cnt_en;
  logic        w_cnt_done;
  logic        w_last;
  logic [31:0] r_if_rdata;
  logic [31:0] r_mem_rdata;
  logic        r_if_ready;
  logic        r_mem_ready;
  logic [31:0] r_sram_addr;
  logic [31:0] r_sram_wdata;
  logic        r_sram_we;
  logic        r_sram_oe;

  assign w_mem_req = mem_r_en | mem_w_en;

`ifdef STARVE_GUARD_EN
  localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);

  logic [c_starve_w-1:0] r_starve_cnt;

  // Never passes STARVE_LIMIT: reaching it with fetch pending forces a fetch grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (w_gnt == GNT_IF) begin
      r_starve_cnt <= '0;
    end else if ((w_gnt == GNT_MEM) && if_req) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign w_force_if = if_req && (r_starve_cnt == c_starve_w'(STARVE_LIMIT));
`else
  assign w_force_if = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_gnt != GNT_NONE) w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_cnt_done)        w_state_nxt = ST_RESP;
      ST_RESP:                          w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_gnt = GNT_NONE;
    if (r_state == ST_IDLE) begin
      if (w_mem_req && !w_force_if) begin
        w_gnt = GNT_MEM;
      end else if (if_req) begin
        w_gnt = GNT_IF;
      end
    end
    w_cnt_load = (w_gnt != GNT_NONE);
    w_cnt_en   = (r_state == ST_ACCESS);
    w_last     = w_cnt_en && w_cnt_done;
  end

  wait_counter u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (w_cnt_load),
    .load_val (c_wait_load),
    .en       (w_cnt_en),
    .done     (w_cnt_done)
  );

  // Strobes are registered on the grant edge so they cover exactly the ACCESS cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt        <= GNT_NONE;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_sram_we    <= 1'b0;
      r_sram_oe    <= 1'b0;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
      r_if_ready   <= 1'b0;
      r_mem_ready  <= 1'b0;
    end else begin
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      if (w_gnt == GNT_MEM) begin
        r_gnt        <= GNT_MEM;
        r_sram_addr  <= mem_addr;
        r_sram_wdata <= mem_wdata;
        r_sram_we    <= mem_w_en;
        r_sram_oe    <= ~mem_w_en;
      end else if (w_gnt == GNT_IF) begin
        r_gnt        <= GNT_IF;
        r_sram_addr  <= if_addr;
        r_sram_wdata <= '0;
        r_sram_we    <= 1'b0;
        r_sram_oe    <= 1'b1;
      end else if (w_last) begin
        r_sram_we <= 1'b0;
        r_sram_oe <= 1'b0;
        if (r_gnt == GNT_MEM) begin
          r_mem_rdata <= sram_rdata;
          r_mem_ready <= 1'b1;
        end else begin
          r_if_rdata <= sram_rdata;
          r_if_ready <= 1'b1;
        end
      end
    end
  end

  assign if_rdata   = r_if_rdata;
  assign if_ready   = r_if_ready;
  assign mem_rdata  = r_mem_rdata;
  assign mem_ready  = r_mem_ready;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_we    = r_sram_we;
  assign sram_oe    = r_sram_oe;
  assign freeze     = w_mem_req & ~r_mem_ready;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Brief    : Directed bench for sram_arbiter with a transaction-timeline model.
// Revision : 1.0
// ============================================================================
module tb_sram_arbiter;

  localparam int W  = 4;
  localparam int SL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        freeze;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_we;
  logic        sram_oe;
  logic [31:0] sram_rdata = '0;

  always #5 clk = ~clk;

  sram_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .freeze(freeze), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_we(sram_we), .sram_oe(sram_oe), .sram_rdata(sram_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-timeline model: a grant in an idle cycle is followed by W
  // access cycles, then one response cycle, then the block is idle again.
  bit          m_busy = 1'b0;
  int          m_phase = 0;
  int          m_kind = 0;       // 1 = fetch, 2 = data
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  bit          m_we = 1'b0;
  logic [31:0] m_cap = '0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_mem_rdata = '0;
  int          m_starve = 0;
  int          grant_log[$];

  always @(negedge clk) begin
    bit e_we, e_oe, e_ifr, e_memr, mreq, force_if;
    if (!rst) begin
      m_busy = 0; m_kind = 0; m_addr = '0; m_we = 0;
      m_if_rdata = '0; m_mem_rdata = '0; m_starve = 0;
      chk("rst_sram_we", 32'(sram_we), 32'd0);
      chk("rst_sram_oe", 32'(sram_oe), 32'd0);
      chk("rst_if_ready", 32'(if_ready), 32'd0);
      chk("rst_mem_ready", 32'(mem_ready), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
      chk("rst_sram_addr", sram_addr, 32'd0);
    end else begin
      e_we = 0; e_oe = 0; e_ifr = 0; e_memr = 0;
      if (m_busy) begin
        m_phase++;
        if (m_phase <= W) begin
          e_we = m_we;
          e_oe = !m_we;
          if (m_phase == W) m_cap = sram_rdata;
        end else begin
          if (m_kind == 2) begin e_memr = 1; m_mem_rdata = m_cap; end
          else             begin e_ifr  = 1; m_if_rdata  = m_cap; end
          m_busy = 0;
        end
      end else begin
        mreq = mem_r_en | mem_w_en;
        force_if = 0;
`ifdef STARVE_GUARD_EN
        force_if = if_req && (m_starve == SL);
`endif
        m_kind = 0;
        if (mreq && !force_if) begin
          m_kind = 2; m_addr = mem_addr; m_wdata = mem_wdata; m_we = mem_w_en;
          if (if_req) m_starve++;
        end else if (if_req) begin
          m_kind = 1; m_addr = if_addr; m_we = 0; m_starve = 0;
        end
        if (m_kind != 0) begin
          m_busy = 1; m_phase = 0; grant_log.push_back(m_kind);
        end
      end
      chk("sram_we", 32'(sram_we), 32'(e_we));
      chk("sram_oe", 32'(sram_oe), 32'(e_oe));
      chk("if_ready", 32'(if_ready), 32'(e_ifr));
      chk("mem_ready", 32'(mem_ready), 32'(e_memr));
      chk("freeze", 32'(freeze), 32'((mem_r_en | mem_w_en) & ~e_memr));
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("mem_rdata", mem_rdata, m_mem_rdata);
      if (e_we || e_oe) chk("sram_addr", sram_addr, m_addr);
      if (e_we) chk("sram_wdata", sram_wdata, m_wdata);
    end
  end

  int we_cnt = 0, oe_cnt = 0, frz_cnt = 0, ifr_cnt = 0, memr_cnt = 0;
  always @(negedge clk) begin
    if (sram_we)   we_cnt++;
    if (sram_oe)   oe_cnt++;
    if (freeze)    frz_cnt++;
    if (if_ready)  ifr_cnt++;
    if (mem_ready) memr_cnt++;
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // cyc = index of the cycle holding the ready pulse, the calling cycle being 0.
  task automatic wait_ready(input bit is_mem, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if ((is_mem ? mem_ready : if_ready) === 1'b1) break;
      cyc++;
      if (cyc > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL wait_ready: got no ready after %0d cycles, want a ready pulse", cyc);
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by t=%0t, want finish", $time);
    $fatal(1);
  end

  initial begin
    int cyc, s0, s1, s2, s3;
    int exp_pat[6];

    repeat (3) next_cycle();
    rst = 1'b1;
    next_cycle();

    // Single read: ready in the sixth cycle counting the request cycle
    s0 = frz_cnt;
    mem_r_en = 1; mem_addr = 32'h40; sram_rdata = 32'hDEADBEEF;
    wait_ready(1, cyc);
    chk("rd_latency", 32'(cyc), 32'(W + 1));
    chk("rd_data", mem_rdata, 32'hDEADBEEF);
    next_cycle();
    chk("rd_freeze_cycles", 32'(frz_cnt - s0), 32'(W + 1));
    mem_r_en = 0;
    next_cycle();

    // Simultaneous fetch and write: data first, fetch six cycles later
    s0 = we_cnt;
    if_req = 1; if_addr = 32'h100;
    mem_w_en = 1; mem_addr = 32'h80; mem_wdata = 32'h12345678; sram_rdata = 32'hCAFE0001;
    wait_ready(1, cyc);
    chk("wr_latency", 32'(cyc), 32'(W + 1));
    next_cycle();
    chk("wr_we_cycles", 32'(we_cnt - s0), 32'(W));
    mem_w_en = 0; sram_rdata = 32'hA5A50F0F;
    wait_ready(0, cyc);
    chk("if_after_wr", 32'(cyc + 1), 32'd6);
    chk("if_data", if_rdata, 32'hA5A50F0F);
    chk("mem_rdata_hold", mem_rdata, 32'hCAFE0001);
    next_cycle();
    if_req = 0;
    next_cycle();

    // Read and write together is a write
    s0 = we_cnt; s1 = oe_cnt;
    mem_r_en = 1; mem_w_en = 1; mem_addr = 32'h33C; mem_wdata = 32'h0BADF00D;
    wait_ready(1, cyc);
    next_cycle();
    chk("rw_we_cycles", 32'(we_cnt - s0), 32'(W));
    chk("rw_oe_cycles", 32'(oe_cnt - s1), 32'd0);
    mem_r_en = 0; mem_w_en = 0;
    next_cycle();

    // Address change mid-access is ignored
    mem_r_en = 1; mem_addr = 32'h10; sram_rdata = 32'h00C0FFEE;
    next_cycle();
    next_cycle();
    mem_addr = 32'h20;
    @(negedge clk);
    chk("addr_held_access", sram_addr, 32'h10);
    wait_ready(1, cyc);
    chk("addr_chg_latency", 32'(cyc), 32'd2);
    chk("addr_held_resp", sram_addr, 32'h10);
    next_cycle();
    mem_r_en = 0;
    next_cycle();

    // Reset in the second access cycle aborts, then the held request restarts
    mem_w_en = 1; mem_addr = 32'h44; mem_wdata = 32'h55;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("we_before_rst", 32'(sram_we), 32'd1);
    s0 = memr_cnt;
    rst = 1'b0;
    #1;
    chk("we_async_drop", 32'(sram_we), 32'd0);
    chk("addr_async_clr", sram_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("no_ready_on_abort", 32'(memr_cnt - s0), 32'd0);
    wait_ready(1, cyc);
    chk("restart_latency", 32'(cyc), 32'(W + 1));
    next_cycle();
    mem_w_en = 0;
    next_cycle();

    // Continuous fetch and data requests
    s0 = grant_log.size(); s2 = ifr_cnt; s3 = memr_cnt;
    if_req = 1; if_addr = 32'h300; mem_r_en = 1; mem_addr = 32'h200;
    repeat (6 * (W + 2)) @(posedge clk);
    #1;
    if_req = 0; mem_r_en = 0;
    next_cycle();
`ifdef STARVE_GUARD_EN
    exp_pat = '{2, 2, 1, 2, 2, 1};
    chk("starve_if_pulses", 32'(ifr_cnt - s2), 32'd2);
    chk("starve_mem_pulses", 32'(memr_cnt - s3), 32'd4);
`else
    exp_pat = '{2, 2, 2, 2, 2, 2};
    chk("strict_if_pulses", 32'(ifr_cnt - s2), 32'd0);
    chk("strict_mem_pulses", 32'(memr_cnt - s3), 32'd6);
`endif
    for (int i = 0; i < 6; i++) begin
      s1 = (s0 + i < grant_log.size()) ? grant_log[s0 + i] : 0;
      chk($sformatf("grant_order[%0d]", i), 32'(s1), 32'(exp_pat[i]));
    end
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
